// File: rtl/sev_seg_mon.sv
// Seven-segment bus monitor: recovers the hex digit shown on each multiplexed position.
// Optional per-digit staleness timeout is enabled by defining SEG_TIMEOUT_EN.
module sev_seg_mon #(
  parameter int N_DIG         = 4,
  parameter int STABLE_CYC    = 4,
  parameter int AN_ACTIVE_LOW = 1,
  parameter int TIMEOUT_CYC   = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DIG-1:0]     an_in,
  input  logic [7:0]           seg_in,
  output logic [4*N_DIG-1:0]   hex_out,
  output logic [N_DIG-1:0]     dp_out,
  output logic [N_DIG-1:0]     dig_valid,
  output logic [N_DIG-1:0]     err_out,
  output logic                 upd_pulse
);

  localparam int CW = $clog2(STABLE_CYC) + 1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [N_DIG-1:0]     an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*N_DIG-1:0]   hex_q, hex_d;
  logic [N_DIG-1:0]     dp_q, dp_d;
  logic [N_DIG-1:0]     valid_q, valid_d;
  logic [N_DIG-1:0]     err_q, err_d;
  logic                 upd_q, upd_d;

  logic [N_DIG-1:0]     an_norm;
  logic                 changed;
  logic                 new_one_hot;
  logic                 capture;
  logic [4:0]           dec;

  function automatic logic is_one_hot(input logic [N_DIG-1:0] v);
    return (v != '0) && ((v & (v - N_DIG'(1))) == '0);
  endfunction

  // Returns {match, nibble}; match=0 for any pattern outside the hex font.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign an_norm     = (AN_ACTIVE_LOW != 0) ? ~an_in : an_in;
  // Change detection compares the incoming sample with the one already registered,
  // so the count restarts on the same edge that captures the new sample.
  assign changed     = (an_norm != an_q) || (seg_in != seg_q);
  assign new_one_hot = is_one_hot(an_norm);
  assign capture     = (state_q == ST_SETTLE) && !changed &&
                       (cnt_q == CW'(STABLE_CYC - 1));
  assign dec         = decode(seg_q[6:0]);

  always_comb begin
    an_d  = an_norm;
    seg_d = seg_in;
    cnt_d = cnt_q;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYC)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (changed && new_one_hot) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (changed)      state_d = new_one_hot ? ST_SETTLE : ST_WAIT;
        else if (capture) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (changed) state_d = new_one_hot ? ST_SETTLE : ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

`ifdef SEG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_q [N_DIG];
  logic [TW-1:0] to_d [N_DIG];
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    hex_d   = hex_q;
    dp_d    = dp_q;
    valid_d = valid_q;
    err_d   = err_q;
    upd_d   = capture;
`ifdef SEG_TIMEOUT_EN
    for (int i = 0; i < N_DIG; i++) to_d[i] = to_q[i];
`endif
    for (int i = 0; i < N_DIG; i++) begin
      if (capture && an_q[i]) begin
        dp_d[i] = seg_q[7];
        if (dec[4]) begin
          hex_d[4*i +: 4] = dec[3:0];
          valid_d[i]      = 1'b1;
          err_d[i]        = 1'b0;
        end else begin
          valid_d[i]      = 1'b0;
          err_d[i]        = 1'b1;
        end
`ifdef SEG_TIMEOUT_EN
        to_d[i] = '0;
      end else begin
        if (to_q[i] != TW'(TIMEOUT_CYC)) to_d[i] = to_q[i] + TW'(1);
        // A stale digit loses its flags silently; the nibble stays for inspection.
        if (to_d[i] == TW'(TIMEOUT_CYC)) begin
          valid_d[i] = 1'b0;
          err_d[i]   = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      an_q    <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
      valid_q <= '0;
      err_q   <= '0;
      upd_q   <= 1'b0;
`ifdef SEG_TIMEOUT_EN
      for (int i = 0; i < N_DIG; i++) to_q[i] <= '0;
`endif
    end else begin
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
`ifdef SEG_TIMEOUT_EN
      for (int i = 0; i < N_DIG; i++) to_q[i] <= to_d[i];
`endif
    end
  end

  assign hex_out   = hex_q;
  assign dp_out    = dp_q;
  assign dig_valid = valid_q;
  assign err_out   = err_q;
  assign upd_pulse = upd_q;

endmodule

// File: tb/tb_sev_seg_mon.sv
// Directed testbench for sev_seg_mon with hand-computed expectations.
// The timeout scenario runs only when SEG_TIMEOUT_EN is defined.
module tb_sev_seg_mon;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an_in;
  logic [7:0]  seg_in;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  dig_valid;
  logic [3:0]  err_out;
  logic        upd_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_total = 0;
  int b2b_count   = 0;
  logic upd_prev  = 1'b0;

  always #5 clk = ~clk;

  sev_seg_mon #(
    .N_DIG(4),
    .STABLE_CYC(4),
    .AN_ACTIVE_LOW(1),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .an_in(an_in),
    .seg_in(seg_in),
    .hex_out(hex_out),
    .dp_out(dp_out),
    .dig_valid(dig_valid),
    .err_out(err_out),
    .upd_pulse(upd_pulse)
  );

  // Pulse monitor: sees the pre-edge value of upd_pulse, so each strobe is counted once.
  always @(posedge clk) begin
    if (upd_pulse) pulse_total <= pulse_total + 1;
    if (upd_pulse && upd_prev) b2b_count <= b2b_count + 1;
    upd_prev <= upd_pulse;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; an_in = 4'hF; seg_in = 8'h00;
    cycles(3);
    n_checks++; if (hex_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_hex got %h want 0000", hex_out); end
    n_checks++; if (dig_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0000", dig_valid); end
    n_checks++; if (err_out !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0000", err_out); end
    n_checks++; if (dp_out !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_dp got %b want 0000", dp_out); end
    n_checks++; if (upd_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_upd got %b want 0", upd_pulse); end
    an_in = 4'b1110; seg_in = 8'h06;
    cycles(7);
    n_checks++; if (dig_valid !== 4'h0 || hex_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_hold valid %b hex %h want 0000/0000", dig_valid, hex_out); end
    an_in = 4'hF; seg_in = 8'h00;
    cycles(1);
    reset = 1'b0;
    cycles(3);
    n_checks++; if (upd_pulse !== 1'b0 || dig_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_release upd %b valid %b want 0/0000", upd_pulse, dig_valid); end
  endtask

  task automatic test_single_digit();
    int p0;
    p0 = pulse_total;
    an_in = 4'b1110; seg_in = 8'h06;
    cycles(4);
    n_checks++; if (upd_pulse !== 1'b0 || dig_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL early_capture upd %b valid %b want 0/0000", upd_pulse, dig_valid); end
    cycles(1);
    n_checks++; if (upd_pulse !== 1'b1) begin n_fail++; $display("[TB] FAIL single_upd got %b want 1", upd_pulse); end
    n_checks++; if (hex_out[3:0] !== 4'h1) begin n_fail++; $display("[TB] FAIL single_hex got %h want 1", hex_out[3:0]); end
    n_checks++; if (dig_valid !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_valid got %b want 0001", dig_valid); end
    cycles(6);
    n_checks++; if (pulse_total - p0 !== 1) begin n_fail++; $display("[TB] FAIL single_pulses got %0d want 1", pulse_total - p0); end
  endtask

  task automatic test_scan();
    logic [7:0] pats [4];
    logic [3:0] an_v;
    int p0;
    pats = '{8'h7F, 8'h39, 8'h5E, 8'h71};
    p0 = pulse_total;
    for (int d = 0; d < 4; d++) begin
      an_v   = ~(4'b0001 << d);
      an_in  = an_v;
      seg_in = (d == 2) ? (pats[d] | 8'h80) : pats[d];
      cycles(8);
    end
    n_checks++; if (hex_out !== 16'hFDC8) begin n_fail++; $display("[TB] FAIL scan_hex got %h want FDC8", hex_out); end
    n_checks++; if (dig_valid !== 4'hF) begin n_fail++; $display("[TB] FAIL scan_valid got %b want 1111", dig_valid); end
    n_checks++; if (dp_out !== 4'b0100) begin n_fail++; $display("[TB] FAIL scan_dp got %b want 0100", dp_out); end
    n_checks++; if (pulse_total - p0 !== 4) begin n_fail++; $display("[TB] FAIL scan_pulses got %0d want 4", pulse_total - p0); end
  endtask

  task automatic test_toggle();
    int p0;
    p0 = pulse_total;
    an_in = 4'b1110;
    for (int k = 0; k < 8; k++) begin
      seg_in = (k % 2 == 1) ? 8'h06 : 8'h3F;
      cycles(3);
    end
    an_in = 4'hF; seg_in = 8'h00;
    cycles(6);
    n_checks++; if (pulse_total - p0 !== 0) begin n_fail++; $display("[TB] FAIL toggle_pulses got %0d want 0", pulse_total - p0); end
    n_checks++; if (hex_out !== 16'hFDC8) begin n_fail++; $display("[TB] FAIL toggle_hex got %h want FDC8", hex_out); end
  endtask

  task automatic test_error();
    int p0;
    p0 = pulse_total;
    an_in = 4'b1101; seg_in = 8'h00;
    cycles(8);
    n_checks++; if (err_out !== 4'b0010) begin n_fail++; $display("[TB] FAIL err_flag got %b want 0010", err_out); end
    n_checks++; if (dig_valid !== 4'b1101) begin n_fail++; $display("[TB] FAIL err_valid got %b want 1101", dig_valid); end
    n_checks++; if (hex_out !== 16'hFDC8) begin n_fail++; $display("[TB] FAIL err_hex got %h want FDC8", hex_out); end
    n_checks++; if (pulse_total - p0 !== 1) begin n_fail++; $display("[TB] FAIL err_pulses got %0d want 1", pulse_total - p0); end
    seg_in = 8'h06;
    cycles(8);
    n_checks++; if (err_out !== 4'b0000 || dig_valid !== 4'hF) begin n_fail++; $display("[TB] FAIL err_recover err %b valid %b want 0000/1111", err_out, dig_valid); end
    n_checks++; if (hex_out !== 16'hFD18) begin n_fail++; $display("[TB] FAIL err_recover_hex got %h want FD18", hex_out); end
    an_in = 4'hF; seg_in = 8'h00;
    cycles(2);
  endtask

  task automatic test_multi_anode();
    int p0;
    p0 = pulse_total;
    an_in = 4'b1100; seg_in = 8'h3F;
    cycles(20);
    an_in = 4'hF; seg_in = 8'h00;
    cycles(10);
    n_checks++; if (pulse_total - p0 !== 0) begin n_fail++; $display("[TB] FAIL multi_pulses got %0d want 0", pulse_total - p0); end
    n_checks++; if (hex_out !== 16'hFD18 || dig_valid !== 4'hF) begin n_fail++; $display("[TB] FAIL multi_state hex %h valid %b want FD18/1111", hex_out, dig_valid); end
  endtask

  task automatic test_back_to_back();
    int p0;
    int b0;
    p0 = pulse_total;
    b0 = b2b_count;
    an_in = 4'b1011; seg_in = 8'h4F;
    cycles(20);
    n_checks++; if (pulse_total - p0 !== 1) begin n_fail++; $display("[TB] FAIL hold_pulses got %0d want 1", pulse_total - p0); end
    n_checks++; if (b2b_count !== b0) begin n_fail++; $display("[TB] FAIL b2b_pulses got %0d want %0d", b2b_count, b0); end
    n_checks++; if (hex_out !== 16'hF318) begin n_fail++; $display("[TB] FAIL hold_hex got %h want F318", hex_out); end
    n_checks++; if (dp_out !== 4'b0000) begin n_fail++; $display("[TB] FAIL hold_dp got %b want 0000", dp_out); end
    an_in = 4'hF; seg_in = 8'h00;
    cycles(2);
  endtask

  task automatic test_reset_mid_settle();
    int p0;
    p0 = pulse_total;
    an_in = 4'b1110; seg_in = 8'h6D;
    cycles(3);
    reset = 1'b1;
    cycles(3);
    n_checks++; if (hex_out !== 16'h0 || dig_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL midreset_out hex %h valid %b want 0000/0000", hex_out, dig_valid); end
    n_checks++; if (err_out !== 4'h0 || dp_out !== 4'h0 || upd_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_flags err %b dp %b upd %b want 0", err_out, dp_out, upd_pulse); end
    an_in = 4'hF; seg_in = 8'h00;
    cycles(1);
    reset = 1'b0;
    cycles(8);
    n_checks++; if (pulse_total - p0 !== 0) begin n_fail++; $display("[TB] FAIL midreset_pulses got %0d want 0", pulse_total - p0); end
    n_checks++; if (dig_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL midreset_after got %b want 0000", dig_valid); end
  endtask

`ifdef SEG_TIMEOUT_EN
  task automatic test_timeout();
    int p0;
    p0 = pulse_total;
    an_in = 4'b1110; seg_in = 8'h66;
    cycles(5);
    n_checks++; if (dig_valid[0] !== 1'b1 || hex_out[3:0] !== 4'h4) begin n_fail++; $display("[TB] FAIL to_capture valid %b hex %h want 1/4", dig_valid[0], hex_out[3:0]); end
    an_in = 4'hF; seg_in = 8'h00;
    cycles(49);
    n_checks++; if (dig_valid[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL to_early got %b want 1", dig_valid[0]); end
    cycles(1);
    n_checks++; if (dig_valid[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL to_expire got %b want 0", dig_valid[0]); end
    n_checks++; if (hex_out[3:0] !== 4'h4 || err_out[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL to_retain hex %h err %b want 4/0", hex_out[3:0], err_out[0]); end
    cycles(3);
    n_checks++; if (pulse_total - p0 !== 1) begin n_fail++; $display("[TB] FAIL to_pulses got %0d want 1", pulse_total - p0); end
  endtask
`endif

  initial begin
    reset = 1'b1; an_in = 4'hF; seg_in = 8'h00;
    test_reset();
    test_single_digit();
    test_scan();
    test_toggle();
    test_error();
    test_multi_anode();
    test_back_to_back();
    test_reset_mid_settle();
`ifdef SEG_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
